// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the UART program loader.
//   SYNC_BYTE      : frame start marker.
//   ERR_*          : values driven on err_code.
//   load_state_t   : frame FSM states (instruction_loader).
//   rx_state_t     : byte receiver states (uart_rx_byte).
// Optional feature macro used by the other files: LOADER_CHECKSUM_EN.
package instruction_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_CHECK
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver.
//   clock      : system clock, rising edge.
//   reset      : synchronous, active-low.
//   rx         : asynchronous serial input, idle high.
//   byte_valid : one-cycle strobe, rx_byte holds the received byte.
//   rx_byte    : last good byte (LSB received first).
//   frame_err  : one-cycle strobe, stop bit sampled low; byte discarded.
// Output semantics: byte_valid and frame_err are single-cycle strobes with
// no back-pressure; the consumer must act in the cycle they are high.
// Receiver state is held in the typed signal 'state' for observation.
module uart_rx_byte
  import instruction_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

  rx_state_t   state;
  rx_state_t   state_nx;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        cnt_clr;
  logic        shift_en;
  logic        stop_ok;
  logic        stop_bad;

  always_ff @(posedge clock) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        // Edge detect rather than level: after a framing error the line may
        // still be low, and that must not start a new byte.
        if (rx_prev && !rx_sync) state_nx = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_CNT) begin
          cnt_clr  = 1'b1;
          // Line back high at mid start bit: a glitch, not a start bit.
          state_nx = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_clr  = 1'b1;
          state_nx = RX_IDLE;
          if (rx_sync) stop_ok  = 1'b1;
          else         stop_bad = 1'b1;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      cnt        <= cnt_clr ? 16'd0 : cnt + 16'd1;
      if (state == RX_IDLE) bit_idx <= '0;
      if (shift_en) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      byte_valid <= stop_ok;
      frame_err  <= stop_bad;
      if (stop_ok) rx_byte <= shreg;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// UART-fed program loader: receives a framed image and writes it into the
// instruction memory write port, holding the core while a frame loads.
// Frame: A5, LEN_H, LEN_L, LEN x (hi, lo) [, CHK when LOADER_CHECKSUM_EN].
//   clock    : system clock, rising edge.
//   reset    : synchronous, active-low.
//   rx       : serial input, idle high, 8N1.
//   im_we    : one-cycle instruction memory write strobe.
//   im_addr  : write address (word index within the frame).
//   im_data  : write data {hi, lo}.
//   cpu_hold : high while a frame is in flight.
//   busy     : frame FSM not in IDLE.
//   done     : sticky, last frame loaded (and checksum matched if enabled).
//   error    : sticky, last frame aborted; err_code gives the cause.
//   err_code : 0 none, 1 stop bit, 2 bad length, 3 timeout / checksum.
// Macro LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and the
// CHECK state; without it done rises the cycle after the last write.
// Frame FSM state is held in the typed signal 'state' for observation.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 10,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [31:0] TO_LAST      = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [16:0] MAX_WORDS    = 17'(2 ** ADDR_W);

  logic              byte_valid;
  logic [7:0]        rx_byte;
  logic              frame_err;

  load_state_t       state;
  load_state_t       state_nx;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       rem;
  logic [7:0]        len_h;
  logic [7:0]        hi_byte;
  logic [31:0]       idle_cnt;
  logic              fin_pend;
  logic [15:0]       len_word;
  logic              timeout;
  logic              start;
  logic              set_done;
  logic              set_err;
  logic [1:0]        err_val;
  logic              wr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    err_val  = ERR_NONE;
    wr       = 1'b0;
    len_word = {len_h, rx_byte};
    timeout  = (state != S_IDLE) && (idle_cnt == TO_LAST);
    if (state == S_IDLE) begin
      // Framing errors and non-sync bytes are ignored while hunting.
      if (byte_valid && rx_byte == SYNC_BYTE) begin
        start    = 1'b1;
        state_nx = S_LEN_H;
      end
    end else if (fin_pend) begin
      // Write cycle of the final word: finish as the strobe drops.
      set_done = 1'b1;
      state_nx = S_IDLE;
    end else if (byte_valid) begin
      // A byte in the same cycle as the timeout wins over it.
      case (state)
        S_LEN_H: state_nx = S_LEN_L;
        S_LEN_L: begin
          if (len_word == 16'd0 || {1'b0, len_word} > MAX_WORDS) begin
            set_err  = 1'b1;
            err_val  = ERR_LEN;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DATA_H;
          end
        end
        S_DATA_H: state_nx = S_DATA_L;
        S_DATA_L: begin
          wr = 1'b1;
          if (rem == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_nx = S_CHECK;
`else
            state_nx = S_DATA_L;
`endif
          end else begin
            state_nx = S_DATA_H;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          state_nx = S_IDLE;
          if (rx_byte == chk) begin
            set_done = 1'b1;
          end else begin
            set_err = 1'b1;
            err_val = ERR_TIMEOUT;
          end
        end
`endif
        default: state_nx = S_IDLE;
      endcase
    end else if (frame_err) begin
      set_err  = 1'b1;
      err_val  = ERR_FRAME;
      state_nx = S_IDLE;
    end else if (timeout) begin
      set_err  = 1'b1;
      err_val  = ERR_TIMEOUT;
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_data  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      addr     <= '0;
      rem      <= '0;
      len_h    <= '0;
      hi_byte  <= '0;
      idle_cnt <= '0;
      fin_pend <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      im_we <= wr;
      // im_addr captures the counter before it advances.
      if (wr) begin
        im_addr <= addr;
        im_data <= {hi_byte, rx_byte};
        addr    <= addr + ADDR_W'(1);
        rem     <= rem - 16'd1;
      end
`ifdef LOADER_CHECKSUM_EN
      fin_pend <= 1'b0;
`else
      fin_pend <= wr && (rem == 16'd1);
`endif
      if (byte_valid && state == S_LEN_H) len_h <= rx_byte;
      if (byte_valid && state == S_LEN_L) rem <= len_word;
      if (byte_valid && state == S_DATA_H) hi_byte <= rx_byte;
`ifdef LOADER_CHECKSUM_EN
      if (byte_valid && (state == S_LEN_H || state == S_LEN_L ||
                         state == S_DATA_H || state == S_DATA_L))
        chk <= chk ^ rx_byte;
`endif
      if (state == S_IDLE || byte_valid) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + 32'd1;
      if (start) begin
        done     <= 1'b0;
        error    <= 1'b0;
        err_code <= ERR_NONE;
        addr     <= '0;
        cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        chk      <= '0;
`endif
      end
      if (set_done) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (set_err) begin
        error    <= 1'b1;
        err_code <= err_val;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule
